// File: rtl/ahb_lite_master_bridge.sv
// AHB-Lite master bridge: turns in-order CPU memory requests into pipelined SINGLE
// transfers, handling wait states, the two-cycle error response and misaligned requests.
module ahb_lite_master_bridge #(
  parameter int         ADDR_WIDTH  = 32,
  parameter int         DATA_WIDTH  = 32,
  parameter logic [3:0] HPROT_VALUE = 4'b0011
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  cpu_req_valid,
  output logic                  cpu_req_ready,
  input  logic                  cpu_req_write,
  input  logic [ADDR_WIDTH-1:0] cpu_req_addr,
  input  logic [2:0]            cpu_req_size,
  input  logic [DATA_WIDTH-1:0] cpu_req_wdata,
  output logic                  cpu_rsp_valid,
  output logic [DATA_WIDTH-1:0] cpu_rsp_rdata,
  output logic                  cpu_rsp_err,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic [1:0]            HTRANS,
  output logic                  HMASTLOCK,
  output logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  input  logic                  HRESP,
  input  logic [DATA_WIDTH-1:0] HRDATA
);
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_DATA, S_DATA, S_ERR2, S_LOCAL_ERR
  } state_e;

  localparam logic [2:0] MAX_SIZE = (DATA_WIDTH == 64) ? 3'd3 : 3'd2;

  state_e                state_q, state_d;
  // The A slot's address and control live directly in the HADDR/HWRITE/HSIZE/HPROT registers
  logic                  a_valid_q, a_valid_d;
  logic [ADDR_WIDTH-1:0] haddr_q, haddr_d;
  logic                  hwrite_q, hwrite_d;
  logic [2:0]            hsize_q, hsize_d;
  logic [3:0]            hprot_q, hprot_d;
  logic [DATA_WIDTH-1:0] a_wdata_q, a_wdata_d;
  logic                  d_valid_q, d_valid_d;
  logic                  d_write_q, d_write_d;
  logic [DATA_WIDTH-1:0] hwdata_q, hwdata_d;
  logic                  cancel_q, cancel_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  logic [2:0] size_mask;
  logic       req_legal, accept_legal, accept_illegal, bus_err1;

  always_comb begin
    case (cpu_req_size)
      3'd0:    size_mask = 3'b000;
      3'd1:    size_mask = 3'b001;
      3'd2:    size_mask = 3'b011;
      default: size_mask = 3'b111;
    endcase
    req_legal = (cpu_req_size <= MAX_SIZE) && ((cpu_req_addr[2:0] & size_mask) == 3'd0);
    // A misaligned request is only taken with the pipeline empty so its error stays in order
    cpu_req_ready = !HRESET && (!a_valid_q || HREADY)
                    && (state_q != S_ERR2) && (state_q != S_LOCAL_ERR)
                    && !(HRESP && !HREADY)
                    && (req_legal || (!a_valid_q && !d_valid_q));
    accept_legal   = cpu_req_valid && cpu_req_ready && req_legal;
    accept_illegal = cpu_req_valid && cpu_req_ready && !req_legal;
    bus_err1       = d_valid_q && HRESP && !HREADY && (state_q != S_ERR2);
  end

  always_comb begin
    state_d     = state_q;
    a_valid_d   = a_valid_q;
    haddr_d     = haddr_q;
    hwrite_d    = hwrite_q;
    hsize_d     = hsize_q;
    hprot_d     = hprot_q;
    a_wdata_d   = a_wdata_q;
    d_valid_d   = d_valid_q;
    d_write_d   = d_write_q;
    hwdata_d    = hwdata_q;
    cancel_d    = cancel_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    case (state_q)
      S_LOCAL_ERR: begin
        // Also reached after an error response whose address-phase partner was cancelled
        rsp_valid_d = cancel_q;
        rsp_err_d   = cancel_q;
        cancel_d    = 1'b0;
        state_d     = S_IDLE;
      end
      S_ERR2: begin
        if (HREADY) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          d_valid_d   = 1'b0;
          state_d     = cancel_q ? S_LOCAL_ERR : S_IDLE;
        end
      end
      default: begin
        if (bus_err1) begin
          cancel_d  = a_valid_q;
          a_valid_d = 1'b0;
          state_d   = S_ERR2;
        end else begin
          if (HREADY) begin
            if (d_valid_q) begin
              rsp_valid_d = 1'b1;
              rsp_err_d   = HRESP;
              rsp_rdata_d = (d_write_q || HRESP) ? '0 : HRDATA;
            end
            d_valid_d = a_valid_q;
            d_write_d = hwrite_q;
            hwdata_d  = (a_valid_q && hwrite_q) ? a_wdata_q : '0;
            a_valid_d = 1'b0;
          end
          if (accept_legal) begin
            a_valid_d = 1'b1;
            haddr_d   = cpu_req_addr;
            hwrite_d  = cpu_req_write;
            hsize_d   = cpu_req_size;
            hprot_d   = HPROT_VALUE;
            a_wdata_d = cpu_req_wdata;
          end
          if (accept_illegal) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            state_d     = S_LOCAL_ERR;
          end else if (a_valid_d && d_valid_d) begin
            state_d = S_ADDR_DATA;
          end else if (a_valid_d) begin
            state_d = S_ADDR;
          end else if (d_valid_d) begin
            state_d = S_DATA;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= S_IDLE;
      a_valid_q   <= 1'b0;
      haddr_q     <= '0;
      hwrite_q    <= 1'b0;
      hsize_q     <= 3'd0;
      hprot_q     <= 4'd0;
      a_wdata_q   <= '0;
      d_valid_q   <= 1'b0;
      d_write_q   <= 1'b0;
      hwdata_q    <= '0;
      cancel_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      a_valid_q   <= a_valid_d;
      haddr_q     <= haddr_d;
      hwrite_q    <= hwrite_d;
      hsize_q     <= hsize_d;
      hprot_q     <= hprot_d;
      a_wdata_q   <= a_wdata_d;
      d_valid_q   <= d_valid_d;
      d_write_q   <= d_write_d;
      hwdata_q    <= hwdata_d;
      cancel_q    <= cancel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign HADDR         = haddr_q;
  assign HWRITE        = hwrite_q;
  assign HSIZE         = hsize_q;
  assign HBURST        = 3'b000;
  assign HPROT         = hprot_q;
  assign HTRANS        = {a_valid_q, 1'b0};
  assign HMASTLOCK     = 1'b0;
  assign HWDATA        = hwdata_q;
  assign cpu_rsp_valid = rsp_valid_q;
  assign cpu_rsp_err   = rsp_err_q;
  assign cpu_rsp_rdata = rsp_rdata_q;
endmodule

// File: doc/ahb_lite_master_bridge.md
# ahb_lite_master_bridge

Parametrised AHB-Lite master bridge between the RISC-V core's memory port and the system AHB-Lite fabric, which carries the AES128 peripheral and memories. It supports pipelined transfers, with the address phase of transfer N+1 overlapping the data phase of transfer N. It also provides byte/half/word/dword sizes, wait states, the two-cycle HRESP error response, and an alignment check. Every CPU request receives exactly one in-order response.

## Interface
Parameters:
- ADDR_WIDTH, 32: HADDR and request address width.
- DATA_WIDTH, 32: bus data width; legal values are 32 and 64.
- HPROT_VALUE, 4'b0011: constant HPROT driven during NONSEQ address phases (non-cacheable, non-bufferable, privileged, data).

Ports:
- HCLK  in  1  clock; all logic on its rising edge.
- HRESET  in  1  synchronous, active-high reset.
- cpu_req_valid  in  1  request offered.
- cpu_req_ready  out  1  request accepted when valid&&ready.
- cpu_req_write  in  1  1=write, 0=read.
- cpu_req_addr  in  ADDR_WIDTH  byte address.
- cpu_req_size  in  3  AHB HSIZE encoding.
- cpu_req_wdata  in  DATA_WIDTH  lane-aligned write data; the bridge does not shift it.
- cpu_rsp_valid  out  1  one-cycle response pulse.
- cpu_rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors.
- cpu_rsp_err  out  1  transfer failed, was cancelled, or was misaligned.
- HADDR  out  ADDR_WIDTH; HWRITE out 1; HSIZE out 3; HBURST out 3 (always 3'b000, SINGLE); HPROT out 4; HTRANS out 2 (IDLE=00 or NONSEQ=10 only); HMASTLOCK out 1 (always 0); HWDATA out DATA_WIDTH.
- HREADY  in  1; HRESP  in  1; HRDATA  in  DATA_WIDTH.

## Operation
- Slots: A holds the request currently in its address phase; D holds the request currently in its data phase.
- States:
  - IDLE: no slot valid.
  - ADDR: A only.
  - ADDR_DATA: A and D.
  - DATA: D only.
  - ERR2: second cycle of an error response.
  - LOCAL_ERR: misaligned request reported.
- All AHB outputs are registered.
- HTRANS=NONSEQ exactly while A is valid. HADDR, HWRITE, HSIZE and HPROT come from A; when A is empty they hold their last value, with HTRANS=IDLE.
- An accepted legal request loads into A at the next edge.
- Ready rule: cpu_req_ready = (A empty || HREADY) && state ∉ {ERR2, LOCAL_ERR} && !(HRESP && !HREADY).
- Legality: legal iff size ≤ log2(DATA_WIDTH/8) and addr is a multiple of 2^size.
- Illegal requests:
  - cpu_req_ready is high for an illegal request only when A and D are both empty.
  - The request never reaches the bus.
  - Next cycle (LOCAL_ERR): rsp_valid=1, err=1.
- On an edge with HREADY=1:
  - D completes: response next cycle, err=HRESP, rdata=HRDATA if read.
  - A moves to D; HWDATA <= A.wdata for writes, else 0.
  - A reloads with the newly accepted request, or becomes empty.
- On an edge with HREADY=0, HRESP=0: no slot moves (wait state); outputs held.
- Error handling:
  - HREADY=0 and HRESP=1 is the error first cycle. At the edge, A (if valid) is cancelled and HTRANS<=IDLE; the state goes to ERR2.
  - At the ERR2 completion edge (HREADY=1, HRESP=1), D responds with err=1.
  - The cancelled A request then responds err=1 on the following cycle.
  - The bridge then returns to IDLE.
- Responses are strictly in acceptance order, and at most one per cycle.

## Timing
- Reset values (the cycle after HRESET sampled high): HADDR=0, HWRITE=0, HSIZE=0, HBURST=0, HPROT=0, HTRANS=IDLE, HMASTLOCK=0, HWDATA=0, cpu_req_ready=0, cpu_rsp_valid=0, cpu_rsp_rdata=0, cpu_rsp_err=0, state IDLE.
- Reset mid-transfer discards both slots with no responses. HRESET has priority over every other event.
- Zero-wait latency: accept at cycle 0, NONSEQ at cycle 1, data phase at cycle 2, cpu_rsp_valid at cycle 3.
- Throughput: one transfer per cycle when requests are back-to-back.
- Each wait cycle (HREADY=0) adds one cycle of latency to both slots.
- cpu_rsp_valid is a single-cycle pulse with no backpressure; the consumer must always accept it.

## Test plan
- Single read, addr 0x0000_0010, size 2, HRDATA=0xCAFEBABE, zero wait -> HTRANS=NONSEQ at cycle 1; rsp at cycle 3 with rdata=0xCAFEBABE, err=0.
- Four back-to-back writes to 0x0, 0x4, 0x8, 0xC, zero wait -> HTRANS NONSEQ for 4 consecutive cycles; HWDATA follows each address by one cycle; 4 consecutive rsp pulses.
- Write then read with 3 wait states on the write -> HADDR and HWDATA held during the 3 cycles; read rsp at cycle 7.
- Read with error response while a pipelined write sits in A -> HTRANS=IDLE in ERR2; two rsp pulses with err=1, in order; then IDLE.
- Half-word at 0x3 and word at 0x2 -> no NONSEQ issued; each gets err=1 one cycle after acceptance. Byte at 0x3 -> issued normally with HSIZE=0.
- HRESET asserted during a wait-state data phase -> every output at its reset value the next cycle; no response for the dropped transfer.
